// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM read/write arbiter.
// SRAM_ARB_STATS_EN (optional define) adds grant/turnaround counters to the top.
package sram_arb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WRITE = 4'b0010,
        ST_READ  = 4'b0100,
        ST_TURN  = 4'b1000
    } state_t;

    typedef enum logic {
        OWNER_WR = 1'b0,
        OWNER_RD = 1'b1
    } owner_t;

    typedef struct packed {
        logic wr;
        logic rd;
    } arb_grant_t;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return tracker: valid shift register matching SRAM latency, plus the
// registered read-data output.
module sram_rd_pipe #(
    parameter int WIDTH   = 72,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue,
    input  logic [WIDTH-1:0] sram_rd_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld
);

    logic [LATENCY:1] vld_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            rd_data  <= '0;
            rd_vld   <= 1'b0;
        end else begin
            vld_pipe[1] <= issue;
            for (int i = 2; i <= LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            rd_vld <= vld_pipe[LATENCY];
            if (vld_pipe[LATENCY])
                rd_data <= sram_rd_data;
        end
    end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Round-robin, burst-limited arbiter sharing one synchronous SRAM between the
// write and read engines. Define SRAM_ARB_STATS_EN to add grant/turn counters.
module sram_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_RD_LATENCY = 3,
    parameter int BURST_MAX       = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             wr_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0]       wr_0_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] wr_0_data,
    output logic                             wr_0_ack,
    input  logic                             rd_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0]       rd_0_addr,
    output logic                             rd_0_ack,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] rd_0_data,
    output logic                             rd_0_vld,
    output logic [SRAM_ADDR_WIDTH-1:0]       sram_addr,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_wr_data,
    output logic                             sram_we,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_rd_data
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]                      num_wr_grants,
    output logic [31:0]                      num_rd_grants,
    output logic [31:0]                      num_turn_cycles
`endif
);

    localparam int W  = DATA_WIDTH + CTRL_WIDTH;
    localparam int CW = log2(BURST_MAX) + 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);
    localparam logic [CW-1:0] BURST_SAT  = CW'(BURST_MAX);

    state_t         state, state_nxt;
    owner_t         last_owner, target, target_nxt, pick;
    logic           dir_vld;
    logic [CW-1:0]  burst_cnt, burst_nxt;
    arb_grant_t     gnt, gnt_raw;
    logic           own_req, oth_req, pick_oth_req;

    assign own_req      = (state == ST_WRITE) ? wr_0_req : rd_0_req;
    assign oth_req      = (state == ST_WRITE) ? rd_0_req : wr_0_req;
    assign pick_oth_req = (pick == OWNER_WR) ? rd_0_req : wr_0_req;

    always_comb begin
        state_nxt = state;
        target_nxt = target;
        burst_nxt = burst_cnt;
        gnt_raw = '0;
        if (wr_0_req && rd_0_req)
            pick = (last_owner == OWNER_RD) ? OWNER_WR : OWNER_RD;
        else
            pick = wr_0_req ? OWNER_WR : OWNER_RD;

        unique case (state)
            ST_IDLE: begin
                if (wr_0_req || rd_0_req) begin
                    // Turnaround only needed if the bus last moved the other way.
                    if (dir_vld && pick != last_owner) begin
                        state_nxt  = ST_TURN;
                        target_nxt = pick;
                        burst_nxt  = '0;
                    end else begin
                        gnt_raw.wr = (pick == OWNER_WR);
                        gnt_raw.rd = (pick == OWNER_RD);
                        if (pick_oth_req && BURST_MAX == 1) begin
                            state_nxt  = ST_TURN;
                            target_nxt = (pick == OWNER_WR) ? OWNER_RD : OWNER_WR;
                            burst_nxt  = '0;
                        end else begin
                            state_nxt = (pick == OWNER_WR) ? ST_WRITE : ST_READ;
                            burst_nxt = CW'(1);
                        end
                    end
                end
            end
            ST_WRITE, ST_READ: begin
                if (own_req) begin
                    gnt_raw.wr = (state == ST_WRITE);
                    gnt_raw.rd = (state == ST_READ);
                    if (oth_req && burst_cnt >= BURST_LAST) begin
                        state_nxt  = ST_TURN;
                        target_nxt = (state == ST_WRITE) ? OWNER_RD : OWNER_WR;
                        burst_nxt  = '0;
                    end else if (burst_cnt != BURST_SAT) begin
                        burst_nxt = burst_cnt + CW'(1);
                    end
                end else if (oth_req) begin
                    state_nxt  = ST_TURN;
                    target_nxt = (state == ST_WRITE) ? OWNER_RD : OWNER_WR;
                    burst_nxt  = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TURN:  state_nxt = (target == OWNER_WR) ? ST_WRITE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Acks are combinational, so hold them off while reset is asserted.
    assign gnt      = reset_n ? gnt_raw : '0;
    assign wr_0_ack = gnt.wr;
    assign rd_0_ack = gnt.rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            target     <= OWNER_WR;
            last_owner <= OWNER_RD;
            dir_vld    <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            burst_cnt <= burst_nxt;
            if (gnt.wr || gnt.rd) begin
                last_owner <= gnt.wr ? OWNER_WR : OWNER_RD;
                dir_vld    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_addr    <= '0;
            sram_wr_data <= '0;
            sram_we      <= 1'b0;
        end else begin
            sram_we <= gnt.wr;
            if (gnt.wr) begin
                sram_addr    <= wr_0_addr;
                sram_wr_data <= wr_0_data;
            end else if (gnt.rd) begin
                sram_addr <= rd_0_addr;
            end
        end
    end

    sram_rd_pipe #(
        .WIDTH   (W),
        .LATENCY (SRAM_RD_LATENCY)
    ) u_rd_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue        (gnt.rd),
        .sram_rd_data (sram_rd_data),
        .rd_data      (rd_0_data),
        .rd_vld       (rd_0_vld)
    );

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_wr_grants   <= '0;
            num_rd_grants   <= '0;
            num_turn_cycles <= '0;
        end else begin
            if (gnt.wr)           num_wr_grants   <= num_wr_grants + 32'd1;
            if (gnt.rd)           num_rd_grants   <= num_rd_grants + 32'd1;
            if (state == ST_TURN) num_turn_cycles <= num_turn_cycles + 32'd1;
        end
    end
`endif

endmodule
